wishbone_to_ahb: RTL and testbench

Bridge from a Wishbone classic slave port to an AHB-Lite master port: the other direction of the existing AHB-to-Wishbone adapter. It lets Wishbone initiators (Controller, debug/loader paths) reach AHB-Lite peripherals and memories. One outstanding transfer at a time, SINGLE bursts only. Byte-select patterns are translated to HSIZE/HADDR[1:0], and HRESP errors are reported as Wishbone err.

---
 rtl/wishbone_to_ahb.sv | 137 +++++++++++++
 tb/tb_wishbone_to_ahb.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/wishbone_to_ahb.sv
// wishbone_to_ahb: Wishbone classic slave to AHB-Lite master bridge, one SINGLE transfer at a time.
module wishbone_to_ahb #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic                  clk_core,
  input  logic                  rst_core,
  input  logic                  wb_cyc,
  input  logic                  wb_stb,
  input  logic                  wb_we,
  input  logic [3:0]            wb_sel,
  input  logic [ADDR_WIDTH-1:0] wb_adr,
  input  logic [DATA_WIDTH-1:0] wb_dat_w,
  output logic [DATA_WIDTH-1:0] wb_dat_r,
  output logic                  wb_ack,
  output logic                  wb_err,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic                  HMASTLOCK,
  output logic [DATA_WIDTH-1:0] HWDATA,
  input  logic [DATA_WIDTH-1:0] HRDATA,
  input  logic                  HREADY,
  input  logic                  HRESP
);
  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;
  localparam logic [1:0] HT_IDLE = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  state_t r_state, w_state;
  logic [ADDR_WIDTH-1:0] r_haddr, w_haddr;
  logic [1:0]            r_htrans, w_htrans;
  logic                  r_hwrite, w_hwrite;
  logic [2:0]            r_hsize, w_hsize;
  logic [DATA_WIDTH-1:0] r_hwdata, w_hwdata;
  logic [DATA_WIDTH-1:0] r_wdat, w_wdat;
  logic [DATA_WIDTH-1:0] r_dat_r, w_dat_r;
  logic                  r_ack, w_ack;
  logic                  r_err, w_err;
  logic                  w_legal;
  logic [2:0]            w_size;
  logic [1:0]            w_lo;
  always_comb begin
    w_legal = 1'b1;
    w_size = 3'b000;
    w_lo = 2'b00;
    case (wb_sel)
      4'b1111: w_size = 3'b010;
      4'b0011: w_size = 3'b001;
      4'b1100: begin w_size = 3'b001; w_lo = 2'b10; end
      4'b0001: w_lo = 2'b00;
      4'b0010: w_lo = 2'b01;
      4'b0100: w_lo = 2'b10;
      4'b1000: w_lo = 2'b11;
      default: w_legal = 1'b0;
    endcase
  end
  // Write data is latched with the request so later bus wiggles cannot leak into the data phase.
  always_comb begin
    w_state = r_state;
    w_haddr = r_haddr;
    w_htrans = r_htrans;
    w_hwrite = r_hwrite;
    w_hsize = r_hsize;
    w_hwdata = r_hwdata;
    w_wdat = r_wdat;
    w_dat_r = r_dat_r;
    w_ack = 1'b0;
    w_err = 1'b0;
    case (r_state)
      S_IDLE: if (wb_cyc && wb_stb) begin
        if (w_legal) begin
          w_haddr = (wb_adr & ~ADDR_WIDTH'(3)) | ADDR_WIDTH'(w_lo);
          w_hsize = w_size;
          w_hwrite = wb_we;
          w_wdat = wb_dat_w;
          w_htrans = HT_NONSEQ;
          w_state = S_ADDR;
        end else begin
          w_err = 1'b1;
          w_state = S_RESP;
        end
      end
      S_ADDR: if (HREADY) begin
        w_htrans = HT_IDLE;
        w_hwdata = r_wdat;
        w_state = S_DATA;
      end
      S_DATA: if (HREADY) begin
        w_dat_r = r_hwrite ? r_dat_r : HRDATA;
        w_ack = wb_cyc && !HRESP;
        w_err = wb_cyc && HRESP;
        w_state = S_RESP;
      end
      default: w_state = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      r_state <= S_IDLE;
      r_haddr <= '0;
      r_htrans <= HT_IDLE;
      r_hwrite <= 1'b0;
      r_hsize <= 3'b010;
      r_hwdata <= '0;
      r_wdat <= '0;
      r_dat_r <= '0;
      r_ack <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_state;
      r_haddr <= w_haddr;
      r_htrans <= w_htrans;
      r_hwrite <= w_hwrite;
      r_hsize <= w_hsize;
      r_hwdata <= w_hwdata;
      r_wdat <= w_wdat;
      r_dat_r <= w_dat_r;
      r_ack <= w_ack;
      r_err <= w_err;
    end
  end
  assign HADDR = r_haddr;
  assign HTRANS = r_htrans;
  assign HWRITE = r_hwrite;
  assign HSIZE = r_hsize;
  assign HWDATA = r_hwdata;
  assign wb_dat_r = r_dat_r;
  assign wb_ack = r_ack;
  assign wb_err = r_err;
  assign HBURST = 3'b000;
  assign HPROT = HPROT_VAL;
  assign HMASTLOCK = 1'b0;
endmodule

// File: tb/tb_wishbone_to_ahb.sv
// tb_wishbone_to_ahb: scoreboard bench for the Wishbone-to-AHB bridge with a scripted AHB slave.
module tb_wishbone_to_ahb;
  logic        clk_core = 1'b0;
  logic        rst_core = 1'b1;
  logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
  logic [3:0]  wb_sel = 4'h0;
  logic [31:0] wb_adr = '0, wb_dat_w = '0, wb_dat_r;
  logic        wb_ack, wb_err;
  logic [31:0] HADDR, HWDATA;
  logic [31:0] HRDATA = '0;
  logic [1:0]  HTRANS;
  logic        HWRITE, HMASTLOCK;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic        HREADY = 1'b1, HRESP = 1'b0;

  wishbone_to_ahb dut (
    .clk_core(clk_core), .rst_core(rst_core), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
    .wb_sel(wb_sel), .wb_adr(wb_adr), .wb_dat_w(wb_dat_w), .wb_dat_r(wb_dat_r), .wb_ack(wb_ack),
    .wb_err(wb_err), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 clk_core = ~clk_core;

  typedef struct packed {
    logic        ack;
    logic        err;
    logic [31:0] dat;
    logic [7:0]  lat;
    logic [7:0]  ntr;
  } res_t;

  res_t        sb[$];
  res_t        g_obs, e;
  logic [31:0] g_addr, g_wdata, m_dat_r;
  logic [2:0]  g_size;
  logic        g_wr;
  int          n_checks = 0, n_fail = 0;

  // One Wishbone request against a slave that inserts aw address-phase and dw data-phase wait states.
  task automatic run_xfer(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                          input logic [31:0] wd, input int aw, input int dw, input logic resp,
                          input logic [31:0] rd, input int drop_at);
    int n = 0, lim;
    bit done = 0;
    lim = (drop_at > 0) ? aw + dw + 5 : 40;
    g_obs = '0;
    g_addr = 'x; g_size = 'x; g_wr = 1'bx; g_wdata = 'x;
    @(posedge clk_core); #1;
    wb_cyc = 1; wb_stb = 1; wb_we = we; wb_adr = adr; wb_sel = sel; wb_dat_w = wd;
    HREADY = 1; HRESP = 0; HRDATA = ~rd;
    while (!done && n < lim) begin
      @(posedge clk_core); #1;
      n++;
      if (HTRANS == 2'b10) begin
        g_obs.ntr++; g_addr = HADDR; g_size = HSIZE; g_wr = HWRITE;
      end
      if (wb_ack || wb_err) begin
        done = 1;
        g_obs.ack = wb_ack; g_obs.err = wb_err; g_obs.dat = wb_dat_r; g_obs.lat = 8'(n);
      end else begin
        HREADY = !((n <= aw) || (n >= aw + 2 && n <= aw + dw + 1));
        HRESP = resp && (n >= aw + dw + 1) && (n <= aw + dw + 2);
        HRDATA = (n == aw + dw + 2) ? rd : ~rd;
        if (n == aw + dw + 2) g_wdata = HWDATA;
        if (n == drop_at) begin wb_cyc = 0; wb_stb = 0; end
      end
    end
    if (drop_at > 0) g_obs.dat = wb_dat_r;
    wb_cyc = 0; wb_stb = 0; HREADY = 1; HRESP = 0; HRDATA = '0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk_core);
    #1;
    n_checks++;
    if ({HTRANS, HADDR, HWRITE, HSIZE, HWDATA, wb_dat_r, wb_ack, wb_err} !==
        {2'b00, 32'h0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state got htrans=%b haddr=%h hwrite=%b hsize=%b hwdata=%h dat_r=%h ack=%b err=%b",
               HTRANS, HADDR, HWRITE, HSIZE, HWDATA, wb_dat_r, wb_ack, wb_err);
    end
    n_checks++;
    if ({HBURST, HPROT, HMASTLOCK} !== {3'b000, 4'b0011, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_consts got hburst=%b hprot=%b hmastlock=%b exp 000/0011/0", HBURST, HPROT, HMASTLOCK);
    end
    rst_core = 0;
    m_dat_r = '0;
  endtask

  task automatic test_word_read();
    m_dat_r = 32'hDEADBEEF;
    sb.push_back('{ack: 1, err: 0, dat: m_dat_r, lat: 3, ntr: 1});
    run_xfer(0, 32'h100, 4'b1111, 32'h0, 0, 0, 0, 32'hDEADBEEF, 0);
    e = sb.pop_front();
    n_checks++;
    if (g_obs !== e) begin n_fail++; $display("FAIL word_read got %h exp %h", g_obs, e); end
    n_checks++;
    if ({g_addr, g_size, g_wr} !== {32'h100, 3'b010, 1'b0}) begin
      n_fail++; $display("FAIL word_read_addr got %h/%b/%b exp 00000100/010/0", g_addr, g_size, g_wr);
    end
  endtask

  task automatic test_byte_write();
    sb.push_back('{ack: 1, err: 0, dat: m_dat_r, lat: 3, ntr: 1});
    run_xfer(1, 32'h203, 4'b0100, 32'h00AB0000, 0, 0, 0, 32'h12345678, 0);
    e = sb.pop_front();
    n_checks++;
    if (g_obs !== e) begin n_fail++; $display("FAIL byte_write got %h exp %h", g_obs, e); end
    n_checks++;
    if ({g_addr, g_size, g_wr, g_wdata} !== {32'h202, 3'b000, 1'b1, 32'h00AB0000}) begin
      n_fail++; $display("FAIL byte_write_addr got %h/%b/%b/%h exp 00000202/000/1/00ab0000", g_addr, g_size, g_wr, g_wdata);
    end
  endtask

  task automatic test_sel_decode();
    logic [3:0] sels[5] = '{4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b1000};
    logic [1:0] los[5] = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b11};
    logic [2:0] szs[5] = '{3'b001, 3'b001, 3'b000, 3'b000, 3'b000};
    for (int i = 0; i < 5; i++) begin
      m_dat_r = 32'hA5000000 + 32'(i);
      sb.push_back('{ack: 1, err: 0, dat: m_dat_r, lat: 3, ntr: 1});
      run_xfer(0, 32'h4000_1000 + 32'(i * 16) + 32'(3 - i % 4), sels[i], 32'h0, 0, 0, 0, m_dat_r, 0);
      e = sb.pop_front();
      n_checks++;
      if (g_obs !== e) begin n_fail++; $display("FAIL sel_%b got %h exp %h", sels[i], g_obs, e); end
      n_checks++;
      if ({g_addr, g_size} !== {32'h4000_1000 + 32'(i * 16) + 32'(los[i]), szs[i]}) begin
        n_fail++; $display("FAIL sel_%b_addr got %h/%b exp lo=%b size=%b", sels[i], g_addr, g_size, los[i], szs[i]);
      end
    end
  endtask

  task automatic test_wait_states();
    m_dat_r = 32'hCAFEF00D;
    sb.push_back('{ack: 1, err: 0, dat: m_dat_r, lat: 8, ntr: 3});
    run_xfer(0, 32'h800, 4'b1111, 32'h0, 2, 3, 0, m_dat_r, 0);
    e = sb.pop_front();
    n_checks++;
    if (g_obs !== e) begin n_fail++; $display("FAIL wait_states got %h exp %h", g_obs, e); end
  endtask

  task automatic test_ahb_error();
    sb.push_back('{ack: 0, err: 1, dat: m_dat_r, lat: 4, ntr: 1});
    run_xfer(1, 32'h900, 4'b1111, 32'h11223344, 0, 1, 1, 32'h0, 0);
    e = sb.pop_front();
    n_checks++;
    if (g_obs !== e) begin n_fail++; $display("FAIL ahb_error got %h exp %h", g_obs, e); end
    #0;
    n_checks++;
    if ({wb_ack, wb_err} !== 2'b00) begin
      @(posedge clk_core); #1;
    end
    @(posedge clk_core); #1;
    if ({wb_ack, wb_err, HTRANS} !== 4'b0000) begin
      n_fail++; $display("FAIL ahb_error_pulse got ack=%b err=%b htrans=%b exp 0/0/00", wb_ack, wb_err, HTRANS);
    end
  endtask

  task automatic test_illegal();
    logic [3:0] bad[3] = '{4'b0110, 4'b0000, 4'b0111};
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{ack: 0, err: 1, dat: m_dat_r, lat: 1, ntr: 0});
      run_xfer(0, 32'hA00, bad[i], 32'h0, 0, 0, 0, 32'h0, 0);
      e = sb.pop_front();
      n_checks++;
      if (g_obs !== e) begin n_fail++; $display("FAIL illegal_%b got %h exp %h", bad[i], g_obs, e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d[3] = '{32'h01020304, 32'h05060708, 32'h090A0B0C};
    for (int i = 0; i < 3; i++) sb.push_back('{ack: 1, err: 0, dat: d[i], lat: 3, ntr: 1});
    for (int i = 0; i < 3; i++) begin
      run_xfer(0, 32'hB00 + 32'(i * 4), 4'b1111, 32'h0, 0, 0, 0, d[i], 0);
      e = sb.pop_front();
      n_checks++;
      if (g_obs !== e) begin n_fail++; $display("FAIL back_to_back_%0d got %h exp %h", i, g_obs, e); end
    end
    m_dat_r = d[2];
  endtask

  task automatic test_cyc_drop();
    m_dat_r = 32'h77665544;
    sb.push_back('{ack: 0, err: 0, dat: m_dat_r, lat: 0, ntr: 1});
    run_xfer(0, 32'hC00, 4'b1111, 32'h0, 0, 2, 0, m_dat_r, 2);
    e = sb.pop_front();
    n_checks++;
    if (g_obs !== e) begin n_fail++; $display("FAIL cyc_drop got %h exp %h", g_obs, e); end
    m_dat_r = 32'h13579BDF;
    sb.push_back('{ack: 1, err: 0, dat: m_dat_r, lat: 3, ntr: 1});
    run_xfer(0, 32'hC04, 4'b1111, 32'h0, 0, 0, 0, m_dat_r, 0);
    e = sb.pop_front();
    n_checks++;
    if (g_obs !== e) begin n_fail++; $display("FAIL cyc_drop_next got %h exp %h", g_obs, e); end
  endtask

  task automatic test_reset_mid();
    @(posedge clk_core); #1;
    wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_adr = 32'h300; wb_sel = 4'b1111; HREADY = 1;
    @(posedge clk_core); #1;
    n_checks++;
    if (HTRANS !== 2'b10) begin n_fail++; $display("FAIL rst_mid_addr got htrans=%b exp 10", HTRANS); end
    @(posedge clk_core); #1;
    HREADY = 0; rst_core = 1; wb_cyc = 0; wb_stb = 0;
    @(posedge clk_core); #1;
    n_checks++;
    if ({HTRANS, wb_ack, wb_err, HADDR} !== {2'b00, 1'b0, 1'b0, 32'h0}) begin
      n_fail++; $display("FAIL rst_mid got htrans=%b ack=%b err=%b haddr=%h exp 00/0/0/0", HTRANS, wb_ack, wb_err, HADDR);
    end
    rst_core = 0; HREADY = 1;
    m_dat_r = 32'h0BADF00D;
    sb.push_back('{ack: 1, err: 0, dat: m_dat_r, lat: 3, ntr: 1});
    run_xfer(0, 32'h304, 4'b1111, 32'h0, 0, 0, 0, m_dat_r, 0);
    e = sb.pop_front();
    n_checks++;
    if (g_obs !== e) begin n_fail++; $display("FAIL rst_mid_next got %h exp %h", g_obs, e); end
  endtask

  initial begin
    test_reset();
    test_word_read();
    test_byte_write();
    test_sel_decode();
    test_wait_states();
    test_ahb_error();
    test_illegal();
    test_back_to_back();
    test_cyc_drop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
